// File: rtl/pack_10_to_16.sv
// LSB-first width converter packing IN_W-bit words into OUT_W-bit bus words through a shift accumulator.
// Optional feature: define PACK_FLUSH_EN to add the flush port, which emits a zero-padded partial word.
module pack_10_to_16 #(
  parameter int IN_W  = 10,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef PACK_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  localparam int ACC_W = OUT_W + IN_W - 1;
  localparam int CNT_W = $clog2(ACC_W + 1);

  localparam logic [CNT_W-1:0] CNT_IN   = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] CNT_OUT  = CNT_W'(OUT_W);
  localparam logic [CNT_W-1:0] CNT_DIFF = CNT_W'(OUT_W - IN_W);

  logic [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [ACC_W-1:0] in_ext;
  logic             in_fire, out_fire;
  logic             flush_req;

`ifdef PACK_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign in_ext    = {{(ACC_W-IN_W){1'b0}}, in_data};
  assign out_valid = (cnt >= CNT_OUT);
  assign out_data  = acc[OUT_W-1:0];
  // A pending flush blocks new input so the padded word is exactly the bits held now.
  assign in_ready  = out_valid ? out_ready : !flush_req;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    acc_nxt = acc;
    cnt_nxt = cnt;
    case ({in_fire, out_fire})
      2'b10: begin
        acc_nxt = acc | (in_ext << cnt);
        cnt_nxt = cnt + CNT_IN;
      end
      2'b01: begin
        acc_nxt = acc >> OUT_W;
        cnt_nxt = cnt - CNT_OUT;
      end
      2'b11: begin
        acc_nxt = (acc >> OUT_W) | (in_ext << (cnt - CNT_OUT));
        cnt_nxt = cnt - CNT_DIFF;
      end
      default: begin
        // Upper acc bits are already zero, so bumping cnt presents a zero-padded word.
        if (flush_req && !out_valid && (cnt != '0))
          cnt_nxt = CNT_OUT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else begin
      acc <= acc_nxt;
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pack_10_to_16.sv
// Directed, table-driven bench for pack_10_to_16 with hand-computed expected bus words.
// Define PACK_FLUSH_EN to also exercise the flush port.
module tb_pack_10_to_16;

  logic        clk;
  logic        rst;
  logic [9:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
`ifdef PACK_FLUSH_EN
  logic        flush;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        in_valid;
    logic [9:0]  in_data;
    logic        out_ready;
    logic        exp_ov;
    logic        chk_od;
    logic [15:0] exp_od;
    logic        exp_ir;
  } vec_t;

  vec_t vecs[$];

  pack_10_to_16 #(.IN_W(10), .OUT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef PACK_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [9:0] id, input logic ordy,
                     input logic eov, input logic cod, input logic [15:0] eod, input logic eir);
    vec_t v;
    v.in_valid = iv;  v.in_data = id;  v.out_ready = ordy;
    v.exp_ov = eov;   v.chk_od = cod;  v.exp_od = eod;  v.exp_ir = eir;
    vecs.push_back(v);
  endtask

  // Each row: drive just after an edge, check just before the next one.
  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(posedge clk);
      #1;
      in_valid  = vecs[i].in_valid;
      in_data   = vecs[i].in_data;
      out_ready = vecs[i].out_ready;
      #1;
      check($sformatf("row%0d out_valid", i), {15'd0, out_valid}, {15'd0, vecs[i].exp_ov});
      check($sformatf("row%0d in_ready", i), {15'd0, in_ready}, {15'd0, vecs[i].exp_ir});
      if (vecs[i].chk_od)
        check($sformatf("row%0d out_data", i), out_data, vecs[i].exp_od);
    end
  endtask

  initial begin
    // Rows 0-9: counting stream 1..8, sink always ready.
    add(1, 10'h001, 1, 0, 0, 16'h0000, 1);
    add(1, 10'h002, 1, 0, 0, 16'h0000, 1);
    add(1, 10'h003, 1, 1, 1, 16'h0801, 1);
    add(1, 10'h004, 1, 0, 0, 16'h0000, 1);
    add(1, 10'h005, 1, 1, 1, 16'h0030, 1);
    add(1, 10'h006, 1, 1, 1, 16'h0501, 1);
    add(1, 10'h007, 1, 0, 0, 16'h0000, 1);
    add(1, 10'h008, 1, 1, 1, 16'h7018, 1);
    add(0, 10'h000, 1, 1, 1, 16'h0200, 1);
    add(0, 10'h000, 1, 0, 1, 16'h0000, 1);
    // Rows 10-19: all-ones stream, no input bubbles.
    add(1, 10'h3FF, 1, 0, 0, 16'h0000, 1);
    add(1, 10'h3FF, 1, 0, 0, 16'h0000, 1);
    add(1, 10'h3FF, 1, 1, 1, 16'hFFFF, 1);
    add(1, 10'h3FF, 1, 0, 0, 16'h0000, 1);
    add(1, 10'h3FF, 1, 1, 1, 16'hFFFF, 1);
    add(1, 10'h3FF, 1, 1, 1, 16'hFFFF, 1);
    add(1, 10'h3FF, 1, 0, 0, 16'h0000, 1);
    add(1, 10'h3FF, 1, 1, 1, 16'hFFFF, 1);
    add(0, 10'h000, 1, 1, 1, 16'hFFFF, 1);
    add(0, 10'h000, 1, 0, 1, 16'h0000, 1);
    // Rows 20-31: sink stalls after two inputs, then the stream resumes.
    add(1, 10'h001, 0, 0, 0, 16'h0000, 1);
    add(1, 10'h002, 0, 0, 0, 16'h0000, 1);
    add(1, 10'h003, 0, 1, 1, 16'h0801, 0);
    add(1, 10'h003, 0, 1, 1, 16'h0801, 0);
    add(1, 10'h003, 1, 1, 1, 16'h0801, 1);
    add(1, 10'h004, 1, 0, 0, 16'h0000, 1);
    add(1, 10'h005, 1, 1, 1, 16'h0030, 1);
    add(1, 10'h006, 1, 1, 1, 16'h0501, 1);
    add(1, 10'h007, 1, 0, 0, 16'h0000, 1);
    add(1, 10'h008, 1, 1, 1, 16'h7018, 1);
    add(0, 10'h000, 1, 1, 1, 16'h0200, 1);
    add(0, 10'h000, 1, 0, 1, 16'h0000, 1);

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
`ifdef PACK_FLUSH_EN
    flush = 1'b0;
`endif
    #3;
    check("reset out_valid", {15'd0, out_valid}, 16'd0);
    check("reset out_data", out_data, 16'h0000);
    check("reset in_ready", {15'd0, in_ready}, 16'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    run_rows(0, 31);

    // Three inputs, then an asynchronous reset between edges.
    run_rows(0, 2);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #1;
    check("partial out_data", out_data, 16'h0030);
    check("partial out_valid", {15'd0, out_valid}, 16'd0);
    #2;
    rst = 1'b1;
    #1;
    check("async rst out_data", out_data, 16'h0000);
    check("async rst out_valid", {15'd0, out_valid}, 16'd0);
    check("async rst in_ready", {15'd0, in_ready}, 16'd1);
    #1;
    rst = 1'b0;
    run_rows(0, 9);

`ifdef PACK_FLUSH_EN
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data = 10'h155;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b1;
    #1;
    check("flush in_ready", {15'd0, in_ready}, 16'd0);
    check("flush pre out_valid", {15'd0, out_valid}, 16'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    #1;
    check("flush out_valid", {15'd0, out_valid}, 16'd1);
    check("flush out_data", out_data, 16'h0155);
    @(posedge clk);
    #2;
    check("flush drained out_valid", {15'd0, out_valid}, 16'd0);
    check("flush drained in_ready", {15'd0, in_ready}, 16'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    #1;
    check("flush empty out_valid", {15'd0, out_valid}, 16'd0);
    run_rows(0, 9);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
